floor_sched: RTL and testbench
==============================

# floor_sched

Sequencing controller for the mod-N up/down binary counter used as the position register. It latches per-position service requests, picks a travel direction with a SCAN policy (keep direction while work remains ahead, else reverse), and steps the counter by driving its `en`/`updown` inputs. On reaching a requested position it holds a dwell window (`door_open`), then continues. It never commands a step that would make the counter wrap.

## Interface
Parameters:
- `X`, 3: position width; must equal the counter's `x`.
- `N`, 6: number of positions; must equal the counter's `n`; N ≤ 2^X.
- `STEP_TICKS`, 4: cycles per counter step (≥ 1).
- `DWELL`, 8: door-open cycles per stop (≥ 1).

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset; one clock, synchronous active-high reset.
- `req` in N: request bit per position; a level sampled every cycle.
- `pos` in X: the counter's `count`.
- `cnt_en` out 1: to counter `en`.
- `cnt_updown` out 1: to counter `updown` (1 = up).
- `door_open` out 1: dwell active at `pos`.
- `busy` out 1: state ≠ IDLE or any pending bit set.
- `pending` out N: latched, unserved requests.

## Operation
- Registers: `state` ∈ {IDLE, MOVE, DOOR}, `dir_up`, `pending[N-1:0]`, `timer`.
- Reset values: state=IDLE, dir_up=1, pending=0, timer=0, cnt_en=0, cnt_updown=1, door_open=0, busy=0.
- `cnt_updown` always equals `dir_up`. Outputs are decoded from registers only; there is no combinational path from `req`.
- Latching: `pending[i]` is set on the edge after `req[i]`=1. It is cleared only on DOOR entry at i. In DOOR, `req[pos]` is not latched (see Configuration).
- "ahead" means any pending bit strictly above `pos` when dir_up=1, or strictly below when dir_up=0. "behind" is the opposite side.
- IDLE:
  - If pending[pos] → DOOR.
  - Else if ahead → MOVE.
  - Else if behind → flip dir_up, MOVE.
  - Otherwise stay in IDLE.
  - MOVE entry loads timer=STEP_TICKS-1.
- MOVE, evaluated every cycle:
  - If pending[pos] → DOOR; no step is taken that cycle.
  - Else if timer≠0, decrement timer.
  - Else assert `cnt_en` for this one cycle and reload timer=STEP_TICKS-1.
- DOOR:
  - On entry: clear pending[pos] and load timer=DWELL-1. `door_open`=1 for exactly DWELL cycles.
  - On expiry: if ahead → MOVE; else if behind → flip dir_up, MOVE; else → IDLE.
- Wrap guard: `cnt_en` is never asserted when (dir_up=1 and pos=N-1) or (dir_up=0 and pos=0). If MOVE reaches that condition with no pending[pos], flip dir_up and reload timer.
- Illegal `pos` ≥ N: force IDLE, no `cnt_en`, pending retained.
- Reset mid-operation: all requests are lost and the counter is not commanded further. The counter's own reset is separate.

## Timing
- Request to first activity: req at cycle t → pending at t+1 → state change at t+2.
- In MOVE, `cnt_en` pulses exactly STEP_TICKS cycles apart. `pos` changes on the edge after each pulse.
- Arrival detection: 1 cycle after `pos` updates. That is, DOOR is entered on the edge following the first cycle where pending[pos]=1.
- DOOR to MOVE: the first `cnt_en` comes STEP_TICKS cycles after DOOR exits.
- Simultaneous events:
  - req for a new position during MOVE is latched and honoured by the SCAN order.
  - req ahead and behind from IDLE with dir_up=1: the unit goes up first.

## Configuration
- `FLOOR_SCHED_REOPEN_EN` defined: `req[pos]`=1 during DOOR reloads timer=DWELL-1, extending the dwell; pending[pos] stays 0.
- Not defined: `req[pos]` during DOOR is ignored, and the dwell is fixed at DWELL cycles.

## Test plan
Conditions: N=6, STEP_TICKS=2, DWELL=3, with the real counter connected.
- Reset, pos=0, pulse req[3] one cycle → three `cnt_en` pulses 2 cycles apart with cnt_updown=1; pos 0→3; door_open high 3 cycles; pending=0; back to IDLE, busy=0.
- At pos 2 moving up toward 5, assert req[0] then req[4] → stops at 4, then 5, then reverses (cnt_updown=0) and stops at 0. The counter never wraps.
- pos=5, IDLE, req[5] → DOOR on the edge after pending[5] sets; zero `cnt_en` pulses.
- req[1] and req[4] together from IDLE at pos 2 → up first: serve 4, then 1.
- During DOOR, hold req[pos] 2 cycles → with macro, door_open lasts 3 cycles past the last req; without macro, exactly 3 cycles.
- Assert reset mid-MOVE → next cycle state=IDLE, pending=0, cnt_en=0, door_open=0, cnt_updown=1.

Source files
------------

// File: rtl/floor_sched_if.sv
// Bundle between the floor scheduler and its environment: the request vector, the position
// counter's count, the counter commands and the scheduler status.
interface floor_sched_if #(
   parameter int X = 3,
   parameter int N = 6
);
   logic [N-1:0] req;
   logic [X-1:0] pos;
   logic         cnt_en;
   logic         cnt_updown;
   logic         door_open;
   logic         busy;
   logic [N-1:0] pending;

   modport master (
      output req, pos,
      input  cnt_en, cnt_updown, door_open, busy, pending
   );

   modport slave (
      input  req, pos,
      output cnt_en, cnt_updown, door_open, busy, pending
   );
endinterface

// File: rtl/floor_sched.sv
// SCAN-policy sequencer for a mod-N up/down position counter: latches requests, steps the
// counter and dwells at each served position. Define FLOOR_SCHED_REOPEN_EN to let req[pos] extend a dwell.
//
//   state | meaning
//   IDLE  | no motion; waits for pending work
//   MOVE  | stepping toward pending work, one counter step every STEP_TICKS cycles
//   DOOR  | dwell at pos for DWELL cycles after serving it
module floor_sched #(
   parameter int X          = 3,
   parameter int N          = 6,
   parameter int STEP_TICKS = 4,
   parameter int DWELL      = 8
) (
   input  logic          clk,
   input  logic          reset,
   floor_sched_if.slave  bus
);

   localparam int TMAX = (STEP_TICKS > DWELL) ? STEP_TICKS : DWELL;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

   state_t        state;
   logic          dir_up;
   logic [N-1:0]  pending;
   logic [TW-1:0] timer;

   logic [N-1:0]  at_pos;
   logic [N-1:0]  above;
   logic [N-1:0]  below;
   logic [N-1:0]  req_latch;
   logic [N-1:0]  pend_nxt;
   logic          pos_ok;
   logic          here;
   logic          ahead;
   logic          behind;
   logic          at_edge;
   logic          step;
   logic          reopen;

   always_comb begin
      at_pos = '0;
      above  = '0;
      below  = '0;
      for (int i = 0; i < N; i++) begin
         at_pos[i] = (bus.pos == X'(i));
         above[i]  = (X'(i) > bus.pos);
         below[i]  = (X'(i) < bus.pos);
      end
   end

   // A position outside 0..N-1 matches no at_pos bit, which doubles as the illegal-pos detect.
   assign pos_ok    = |at_pos;
   assign here      = |(pending & at_pos);
   assign ahead     = dir_up ? |(pending & above) : |(pending & below);
   assign behind    = dir_up ? |(pending & below) : |(pending & above);
   assign at_edge   = dir_up ? (bus.pos == X'(N - 1)) : (bus.pos == '0);
   assign req_latch = (state == DOOR) ? (bus.req & ~at_pos) : bus.req;
   assign pend_nxt  = pending | req_latch;

`ifdef FLOOR_SCHED_REOPEN_EN
   assign reopen = |(bus.req & at_pos);
`else
   assign reopen = 1'b0;
`endif

   // Decoded from the current pos so an arrival suppresses the very next step.
   assign step = (state == MOVE) && pos_ok && !here && (timer == '0) && !at_edge;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         dir_up  <= 1'b1;
         pending <= '0;
         timer   <= '0;
      end else begin
         pending <= pend_nxt;
         if (!pos_ok) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (here) begin
                     state   <= DOOR;
                     pending <= pend_nxt & ~at_pos;
                     timer   <= TW'(DWELL - 1);
                  end else if (ahead) begin
                     state <= MOVE;
                     timer <= TW'(STEP_TICKS - 1);
                  end else if (behind) begin
                     state  <= MOVE;
                     dir_up <= !dir_up;
                     timer  <= TW'(STEP_TICKS - 1);
                  end
               end
               MOVE: begin
                  if (here) begin
                     state   <= DOOR;
                     pending <= pend_nxt & ~at_pos;
                     timer   <= TW'(DWELL - 1);
                  end else if (at_edge) begin
                     dir_up <= !dir_up;
                     timer  <= TW'(STEP_TICKS - 1);
                  end else if (timer != '0) begin
                     timer <= timer - 1'b1;
                  end else begin
                     timer <= TW'(STEP_TICKS - 1);
                  end
               end
               DOOR: begin
                  if (reopen) begin
                     timer <= TW'(DWELL - 1);
                  end else if (timer != '0) begin
                     timer <= timer - 1'b1;
                  end else if (ahead) begin
                     state <= MOVE;
                     timer <= TW'(STEP_TICKS - 1);
                  end else if (behind) begin
                     state  <= MOVE;
                     dir_up <= !dir_up;
                     timer  <= TW'(STEP_TICKS - 1);
                  end else begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.cnt_en     = step;
   assign bus.cnt_updown = dir_up;
   assign bus.door_open  = (state == DOOR);
   assign bus.busy       = (state != IDLE) || (|pending);
   assign bus.pending    = pending;

endmodule

// File: tb/tb_floor_sched.sv
// Bench for floor_sched driving a behavioural mod-N up/down counter; expected stop positions
// are queued per scenario and checked whenever door_open rises.
module tb_floor_sched;
   localparam int X  = 3;
   localparam int N  = 6;
   localparam int ST = 2;
   localparam int DW = 3;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         ld = 1'b0;
   logic [X-1:0] ld_val = '0;
   logic [X-1:0] count = '0;

   int vectors = 0;
   int miscompares = 0;
   int sb[$];
   logic door_q = 1'b0;

   floor_sched_if #(.X(X), .N(N)) bus ();

   floor_sched #(.X(X), .N(N), .STEP_TICKS(ST), .DWELL(DW)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Position counter, wrapping like the real part so a bad command would be visible.
   always @(posedge clk) begin
      if (ld) count <= ld_val;
      else if (bus.cnt_en) begin
         if (bus.cnt_updown) count <= (count == X'(N - 1)) ? '0 : count + 1'b1;
         else                count <= (count == '0) ? X'(N - 1) : count - 1'b1;
      end
   end
   assign bus.pos = count;

   always @(negedge clk) begin
      if (bus.door_open === 1'b1 && !door_q) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL stop_unexpected: door opened at pos %0d, no stop expected", bus.pos);
         end else begin
            int e;
            e = sb.pop_front();
            if (int'(bus.pos) !== e) begin
               miscompares++;
               $display("FAIL stop_pos: got %0d expected %0d", bus.pos, e);
            end
         end
      end
      door_q = (bus.door_open === 1'b1);
      if (bus.cnt_en === 1'b1) begin
         vectors++;
         if ((bus.cnt_updown && bus.pos == X'(N - 1)) || (!bus.cnt_updown && bus.pos == '0)) begin
            miscompares++;
            $display("FAIL wrap_guard: step at pos %0d updown %0b", bus.pos, bus.cnt_updown);
         end
      end
   end

   task automatic do_reset(input int p);
      @(negedge clk);
      reset  = 1'b1;
      ld     = 1'b1;
      ld_val = X'(p);
      bus.req = '0;
      @(negedge clk);
      reset = 1'b0;
      ld    = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(0);
      vectors++;
      if (bus.cnt_en !== 1'b0 || bus.cnt_updown !== 1'b1 || bus.door_open !== 1'b0 ||
          bus.busy !== 1'b0 || bus.pending !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: en %b ud %b door %b busy %b pend %b required 0 1 0 0 000000",
                  bus.cnt_en, bus.cnt_updown, bus.door_open, bus.busy, bus.pending);
      end
   endtask

   task automatic test_single();
      int pulses = 0, first = -1, last = -1, dfirst = -1, dlen = 0;
      bit gap_bad = 0, dir_bad = 0;
      do_reset(0);
      sb.push_back(3);
      bus.req = 6'b001000;
      @(negedge clk);
      bus.req = '0;
      vectors++;
      if (bus.pending !== 6'b001000 || bus.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL single_latch: pending %b busy %b required 001000 1", bus.pending, bus.busy);
      end
      for (int c = 1; c <= 20; c++) begin
         if (bus.cnt_en) begin
            pulses++;
            if (!bus.cnt_updown) dir_bad = 1;
            if (first < 0) first = c;
            else if (c - last != ST) gap_bad = 1;
            last = c;
         end
         if (bus.door_open) begin
            dlen++;
            if (dfirst < 0) dfirst = c;
         end
         @(negedge clk);
      end
      vectors++;
      if (pulses != 3 || first != 3 || gap_bad || dir_bad) begin
         miscompares++;
         $display("FAIL single_steps: pulses %0d first %0d gap_bad %0b dir_bad %0b required 3 3 0 0",
                  pulses, first, gap_bad, dir_bad);
      end
      vectors++;
      if (dfirst != 9 || dlen != DW) begin
         miscompares++;
         $display("FAIL single_door: first %0d len %0d required 9 %0d", dfirst, dlen, DW);
      end
      vectors++;
      if (bus.pos !== 3'd3 || bus.pending !== '0 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL single_end: pos %0d pending %b busy %b required 3 000000 0",
                  bus.pos, bus.pending, bus.busy);
      end
   endtask

   task automatic test_scan();
      int up = 0, dn = 0;
      do_reset(2);
      sb.push_back(4);
      sb.push_back(5);
      sb.push_back(0);
      bus.req = 6'b100000;
      @(negedge clk);
      bus.req = 6'b000001;
      @(negedge clk);
      bus.req = 6'b010000;
      @(negedge clk);
      bus.req = '0;
      for (int c = 3; c <= 40; c++) begin
         if (bus.cnt_en) begin
            if (bus.cnt_updown) up++;
            else dn++;
         end
         @(negedge clk);
      end
      vectors++;
      if (up != 3 || dn != 5) begin
         miscompares++;
         $display("FAIL scan_steps: up %0d down %0d required 3 5", up, dn);
      end
      vectors++;
      if (bus.pos !== 3'd0 || bus.busy !== 1'b0 || bus.cnt_updown !== 1'b0) begin
         miscompares++;
         $display("FAIL scan_end: pos %0d busy %b ud %b required 0 0 0", bus.pos, bus.busy, bus.cnt_updown);
      end
   endtask

   task automatic test_top();
      int pulses = 0, dfirst = -1;
      do_reset(5);
      sb.push_back(5);
      bus.req = 6'b100000;
      @(negedge clk);
      bus.req = '0;
      for (int c = 1; c <= 10; c++) begin
         if (bus.cnt_en) pulses++;
         if (bus.door_open && dfirst < 0) dfirst = c;
         @(negedge clk);
      end
      vectors++;
      if (pulses != 0 || dfirst != 2 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL top_stop: pulses %0d door_first %0d busy %b required 0 2 0", pulses, dfirst, bus.busy);
      end
   endtask

   task automatic test_both();
      int up = 0, dn = 0, first_ud = -1;
      do_reset(2);
      sb.push_back(4);
      sb.push_back(1);
      bus.req = 6'b010010;
      @(negedge clk);
      bus.req = '0;
      for (int c = 1; c <= 40; c++) begin
         if (bus.cnt_en) begin
            if (first_ud < 0) first_ud = int'(bus.cnt_updown);
            if (bus.cnt_updown) up++;
            else dn++;
         end
         @(negedge clk);
      end
      vectors++;
      if (first_ud != 1 || up != 2 || dn != 3 || bus.pos !== 3'd1 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL both_order: first_ud %0d up %0d down %0d pos %0d busy %b required 1 2 3 1 0",
                  first_ud, up, dn, bus.pos, bus.busy);
      end
   endtask

   task automatic test_reopen();
      int dlen = 0, pulses = 0;
`ifdef FLOOR_SCHED_REOPEN_EN
      int exp_len = DW + 2;
`else
      int exp_len = DW;
`endif
      do_reset(1);
      sb.push_back(1);
      bus.req = 6'b000010;
      @(negedge clk);
      bus.req = '0;
      @(negedge clk);
      vectors++;
      if (bus.door_open !== 1'b1) begin
         miscompares++;
         $display("FAIL reopen_entry: door_open %b required 1", bus.door_open);
      end
      for (int c = 2; c <= 16; c++) begin
         bus.req = (c == 2 || c == 3) ? 6'b000010 : 6'b000000;
         if (bus.door_open) dlen++;
         if (bus.cnt_en) pulses++;
         @(negedge clk);
      end
      vectors++;
      if (dlen != exp_len || pulses != 0 || bus.pending !== '0 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reopen_dwell: len %0d pulses %0d pending %b busy %b required %0d 0 000000 0",
                  dlen, pulses, bus.pending, bus.busy, exp_len);
      end
   endtask

   task automatic test_reset_mid();
      bit seen = 0;
      int pulses = 0;
      do_reset(0);
      bus.req = 6'b100000;
      @(negedge clk);
      bus.req = '0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (bus.cnt_en) seen = 1;
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL midreset_move: no cnt_en within 20 cycles, required a step");
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      vectors++;
      if (bus.cnt_en !== 1'b0 || bus.door_open !== 1'b0 || bus.cnt_updown !== 1'b1 ||
          bus.pending !== '0 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_state: en %b door %b ud %b pend %b busy %b required 0 0 1 000000 0",
                  bus.cnt_en, bus.door_open, bus.cnt_updown, bus.pending, bus.busy);
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.cnt_en || bus.busy) pulses++;
      end
      vectors++;
      if (pulses != 0) begin
         miscompares++;
         $display("FAIL midreset_quiet: active cycles %0d required 0", pulses);
      end
   endtask

   initial begin
      bus.req = '0;
      test_reset();
      test_single();
      test_scan();
      test_top();
      test_both();
      test_reopen();
      test_reset_mid();
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL stops_missing: %0d expected stops never served, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
